// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake into a small FIFO,
// serialised LSB first at a fixed number of clock cycles per bit.
module uart_tx_fifo #(
    parameter int CLK_FREQ       = 30_000_000,
    parameter int BAUD           = 9600,
    parameter int CYCLES_PER_BIT = 3125,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
    localparam int CNT_W  = $clog2(CYCLES_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_FW-1:0] FIFO_FULL = CNT_FW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    generate
        if (CYCLES_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
            || CLK_FREQ <= 0 || BAUD <= 0) begin : g_param_check
            $error("uart_tx_fifo: invalid parameter set");
        end
    endgenerate

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             queued;

    // A pop only happens when a new frame starts: from IDLE, or on the last STOP cycle.
    always_comb begin
        queued  = (fifo_count != '0);
        bit_end = (bit_cnt == BIT_LAST);
        push    = tx_valid && tx_ready;
        pop     = queued && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    end

    always_comb begin
        tx_ready = (fifo_count != FIFO_FULL);
        busy     = (state != S_IDLE) || queued;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_FW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        state   <= S_START;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (bit_end) begin
                        done    <= 1'b1;
                        bit_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a line monitor decodes frames against a
// byte scoreboard; a second instance checks default-parameter bit timing.
module tb_uart_tx_fifo;
    localparam int CPB     = 4;
    localparam int FRAME   = 10 * CPB;
    localparam int DEF_CPB = 3125;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx, busy, done;
    logic [3:0] fifo_count;
    logic [7:0] d_tx_data;
    logic       d_tx_valid;
    logic       d_tx_ready, d_tx, d_busy, d_done;
    logic [3:0] d_fifo_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ(40), .BAUD(10), .CYCLES_PER_BIT(CPB), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(
        .CLK_FREQ(30_000_000), .BAUD(9600), .CYCLES_PER_BIT(DEF_CPB), .FIFO_DEPTH(8)
    ) dut_def (
        .clk(clk), .rst_n(rst_n), .tx_data(d_tx_data), .tx_valid(d_tx_valid),
        .tx_ready(d_tx_ready), .tx(d_tx), .busy(d_busy), .done(d_done), .fifo_count(d_fifo_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];
    int starts[$];
    int cyc = 0;
    int frames_done = 0;
    int frames_started = 0;
    int done_cnt = 0;

    logic             mon_active = 1'b0;
    int               mon_pos = 0;
    logic             done_early;
    logic [FRAME-1:0] got;
    logic [FRAME-1:0] exp_line;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME-1:0] line_of(input logic [7:0] b);
        logic [FRAME-1:0] l;
        int bit_no;
        for (int k = 0; k < FRAME; k++) begin
            bit_no = k / CPB;
            if (bit_no == 0)      l[k] = 1'b0;
            else if (bit_no == 9) l[k] = 1'b1;
            else                  l[k] = b[bit_no-1];
        end
        return l;
    endfunction

    // Cycle-accurate line capture: every frame is compared bit-for-bit, including durations.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (mon_active && mon_pos == FRAME) begin
                chk("done_at_frame_end", done, 1);
                chk("no_early_done", done_early, 0);
                chk("frame_line", got, exp_line);
                frames_done++;
                mon_active = 1'b0;
            end
            if (!mon_active && tx === 1'b0) begin
                frames_started++;
                starts.push_back(cyc);
                chk("sb_has_byte", sb.size() != 0, 1);
                if (sb.size() != 0) exp_line = line_of(sb.pop_front());
                else                exp_line = '1;
                mon_active = 1'b1;
                mon_pos    = 0;
                done_early = 1'b0;
            end
            if (mon_active) begin
                got[mon_pos] = tx;
                if (mon_pos > 0 && done === 1'b1) done_early = 1'b1;
                mon_pos++;
            end
        end
    end

    initial begin
        int n, bad, fb, db, fs, s0, run, bits;
        logic prev;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; d_tx_valid = 1'b0; d_tx_data = '0;
        step();
        chk("rst_tx", tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", fifo_count, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // single byte 0xA5
        tx_data = 8'hA5; tx_valid = 1'b1; sb.push_back(8'hA5);
        step();
        tx_valid = 1'b0;
        chk("t1_count_after_push", fifo_count, 1);
        chk("t1_busy_after_push", busy, 1);
        chk("t1_tx_before_pop", tx, 1);
        step();
        chk("t1_tx_falls", tx, 0);
        chk("t1_count_after_pop", fifo_count, 0);
        n = 0;
        while (done !== 1'b1 && n < 100) begin step(); n++; end
        chk("t1_done_latency", n, FRAME);
        chk("t1_busy_drops_with_done", busy, 0);
        step();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_frames", frames_done, 1);

        // burst with backpressure
        fb = frames_done; db = done_cnt; s0 = starts.size();
        for (int i = 0; i < 10; i++) begin
            tx_data = 8'(i); tx_valid = 1'b1;
            chk("t2_ready_during_burst", tx_ready, (i < 9));
            if (i < 9) sb.push_back(8'(i));
            step();
        end
        n = 10; bad = 0;
        while (done !== 1'b1 && n < 100) begin
            if (tx_ready !== 1'b0) bad++;
            step(); n++;
        end
        chk("t2_ready_low_until_done", bad, 0);
        chk("t2_first_done_edge", n, 2 + FRAME);
        chk("t2_ready_after_done", tx_ready, 1);
        chk("t2_count_at_first_done", fifo_count, 7);
        sb.push_back(8'h09);
        step();
        tx_valid = 1'b0;
        chk("t2_count_after_late_push", fifo_count, 8);
        n = 0;
        while (frames_done < fb + 10 && n < 600) begin step(); n++; end
        chk("t2_all_frames", frames_done - fb, 10);
        chk("t2_done_pulses", done_cnt - db, 10);
        bad = 0;
        for (int i = s0 + 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != FRAME) bad++;
        chk("t2_contiguous", bad, 0);
        chk("t2_idle_after", busy, 0);
        chk("t2_sb_drained", sb.size(), 0);

        // push coinciding with the last STOP edge while one byte is queued
        fb = frames_done;
        tx_data = 8'h3C; tx_valid = 1'b1; sb.push_back(8'h3C);
        step();
        tx_valid = 1'b0;
        step();
        chk("t3_frame_started", tx, 0);
        for (int k = 1; k <= FRAME - 1; k++) begin
            if (k == 5) begin tx_data = 8'hC3; tx_valid = 1'b1; sb.push_back(8'hC3); end
            else tx_valid = 1'b0;
            step();
        end
        chk("t3_count_before", fifo_count, 1);
        tx_data = 8'h5A; tx_valid = 1'b1; sb.push_back(8'h5A);
        step();
        tx_valid = 1'b0;
        chk("t3_count_held", fifo_count, 1);
        chk("t3_done_at_collision", done, 1);
        chk("t3_back_to_back_start", tx, 0);
        n = 0;
        while (frames_done < fb + 3 && n < 300) begin step(); n++; end
        chk("t3_frames", frames_done - fb, 3);

        // data extremes back-to-back
        fb = frames_done;
        tx_data = 8'h00; tx_valid = 1'b1; sb.push_back(8'h00);
        step();
        tx_data = 8'hFF; sb.push_back(8'hFF);
        step();
        tx_valid = 1'b0;
        n = 0;
        while (frames_done < fb + 2 && n < 300) begin step(); n++; end
        chk("t4_frames", frames_done - fb, 2);
        chk("t4_back_to_back", starts[starts.size()-1] - starts[starts.size()-2], FRAME);

        // reset during data bit 3 with three bytes queued
        tx_valid = 1'b1;
        tx_data = 8'hF0; sb.push_back(8'hF0); step();
        tx_data = 8'h11; sb.push_back(8'h11); step();
        tx_data = 8'h22; sb.push_back(8'h22); step();
        tx_data = 8'h33; sb.push_back(8'h33); step();
        tx_valid = 1'b0;
        repeat (15) step();
        chk("t5_tx_bit3_before_reset", tx, 0);
        chk("t5_count_before_reset", fifo_count, 3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", tx_ready, 1);
        chk("t5_rst_done", done, 0);
        sb.delete();
        repeat (2) step();
        rst_n = 1'b1;
        fs = frames_started; db = done_cnt; bad = 0;
        repeat (100) begin
            step();
            if (tx !== 1'b1) bad++;
        end
        chk("t5_no_line_activity", bad, 0);
        chk("t5_no_new_frames", frames_started - fs, 0);
        chk("t5_no_done", done_cnt - db, 0);
        chk("t5_idle", busy, 0);

        // default parameters, 0x55 alternates the line at every bit boundary
        d_tx_data = 8'h55; d_tx_valid = 1'b1;
        step();
        d_tx_valid = 1'b0;
        step();
        chk("t6_tx_falls", d_tx, 0);
        n = 0; run = 0; bad = 0; bits = 0; prev = 1'b0;
        while (d_done !== 1'b1 && n < 32000) begin
            step(); n++; run++;
            if (d_tx !== prev) begin
                if (run != DEF_CPB) bad++;
                bits++; run = 0; prev = d_tx;
            end
        end
        chk("t6_frame_cycles", n, 10 * DEF_CPB);
        chk("t6_bit_lengths", bad, 0);
        chk("t6_transitions", bits, 9);
        chk("t6_stop_len", run, DEF_CPB);
        chk("t6_idle_after", d_busy, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the CipherCore-Lite serial path. It accepts bytes from the core over a valid/ready handshake into an internal FIFO and serialises them onto the line as 8N1 frames, LSB first, at a fixed bit period. It pairs with the synchronised receive path, so the core can queue response bytes without tracking line timing.

## Interface
- `CLK_FREQ`, 30_000_000, system clock frequency in Hz (informational).
- `BAUD`, 9600, line rate in bit/s (informational).
- `CYCLES_PER_BIT`, 3125, clock cycles per serial bit (CLK_FREQ/BAUD); must be >= 2.
- `FIFO_DEPTH`, 8, byte entries; power of two, >= 2.

- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `tx_data`  input  8  byte to queue.
- `tx_valid`  input  1  `tx_data` is valid this cycle.
- `tx_ready`  output  1  FIFO can accept a byte; high when `fifo_count != FIFO_DEPTH`.
- `tx`  output  1  serial line, registered; idles high.
- `busy`  output  1  high when the FSM is not IDLE or `fifo_count != 0`.
- `done`  output  1  one-cycle pulse at the end of each frame's stop bit.
- `fifo_count`  output  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the byte in flight.

## Operation
- A push occurs when `tx_valid && tx_ready` at a rising edge. The byte is written at the write pointer, and the pointer wraps modulo FIFO_DEPTH.
- When full, `tx_ready` is low, pushes are ignored, and the FIFO contents are unchanged.
- A pop occurs only when the FSM leaves IDLE or STOP to start a new frame. The popped byte is loaded into the shift register.
- A push and a pop on the same edge leave `fifo_count` unchanged. There is no bypass: a byte pushed into an empty FIFO is popped on the next edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `fifo_count != 0`: pop, go to START, and clear the bit counter.
  - START: `tx`=0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CYCLES_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for CYCLES_PER_BIT cycles. On the final edge of STOP, `done` is set for one cycle, and then:
    - if `fifo_count != 0`: pop and go directly to START (back-to-back, no idle gap);
    - otherwise: go to IDLE.
- The bit counter counts 0..CYCLES_PER_BIT-1 with width $clog2(CYCLES_PER_BIT). It wraps to 0 on each bit boundary.
- A frame is exactly 10*CYCLES_PER_BIT cycles.
- Reset (async, at any point, including mid-frame):
  - `tx`=1, `done`=0, FSM=IDLE;
  - pointers and `fifo_count` = 0, so `busy`=0 and `tx_ready`=1;
  - the in-flight byte and queued bytes are discarded.
  - After release, nothing is transmitted until a new push.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `done`=0, `fifo_count`=0.
- Byte pushed at edge E into an empty FIFO with the FSM in IDLE:
  - `fifo_count`=1 after E;
  - the pop happens at E+1, where `tx` falls and `fifo_count` returns to 0;
  - `done` goes high at E+1+10*CYCLES_PER_BIT for one cycle.
- `busy` goes high after E and stays high through the last stop-bit cycle. It drops together with the `done` pulse if nothing is queued.
- `tx_ready` is combinational from `fifo_count`. It rises the cycle after the pop that frees an entry.
- `tx` has no glitches: it is only ever driven from a flop.

## Test plan
- **Single byte 0xA5**, CYCLES_PER_BIT=4, single-byte push:
  - `tx` falls one edge after the push;
  - line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - one `done` pulse exactly 40 cycles after `tx` falls; `busy` low afterwards.
- **Burst and backpressure**, depth 8, CYCLES_PER_BIT=4, ten consecutive valid cycles with bytes 0x00..0x09:
  - bytes 0x00..0x08 are accepted (0x00 is popped at the second edge);
  - `tx_ready` is low from the 10th cycle until the first `done`, then 0x09 is accepted;
  - 10 frames are sent contiguously with no idle cycles; 10 `done` pulses, 40 cycles apart.
- **Simultaneous push/pop**, with `fifo_count`=1 and a push coinciding with the end of STOP: `fifo_count` stays 1, and the next frame carries the older byte (FIFO order preserved).
- **Data extremes**, 0x00 then 0xFF back-to-back: the line shows the start bit, then 8 lows, stop, start, 8 highs, stop. The stop bit of frame 1 is high for exactly CYCLES_PER_BIT cycles.
- **Reset mid-frame**, `rst_n` pulsed low during data bit 3 with 3 bytes queued:
  - `tx`=1, `fifo_count`=0, `busy`=0, `tx_ready`=1 immediately, without waiting for a clock edge;
  - no `done` pulse and no further line activity after release.
- **Default parameters**, 0x55 sent: each bit lasts exactly 3125 cycles, and the frame takes 31250 cycles from the start-bit edge to the `done` pulse.
